// File: rtl/seven_segment_capture.sv
// seven_segment_capture: samples muxed active-low 4-digit seven-segment lines (enable, led_out), decodes settled phases into digits/valid/blank/dp, flags frame_valid, decode_err, timeout
module seven_segment_capture #(
  parameter bit HEX = 1'b0,
  parameter int SETTLE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  enable,
  input  logic [7:0]  led_out,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic [3:0]  digit_blank,
  output logic [3:0]  digit_dp,
  output logic        frame_valid,
  output logic        decode_err,
  output logic        timeout
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [127:0] SEG = {8'h71, 8'h61, 8'h85, 8'h63, 8'hC1, 8'h11, 8'h09, 8'h01,
                                  8'h1F, 8'h41, 8'h49, 8'h99, 8'h0D, 8'h25, 8'h9F, 8'h03};
  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURED} state_t;
  state_t state, state_next;
  logic [3:0] en_q, en_p, seen, sel, value;
  logic [7:0] led_q, led_p;
  logic [CW-1:0] cnt, cnt_next;
  logic [TW-1:0] tcnt;
  logic [1:0] idx;
  logic legal, changed, hold, cap, known, ok, blank, frame;
  assign legal = $onehot(~en_q);
  assign idx = !en_q[0] ? 2'd0 : !en_q[1] ? 2'd1 : !en_q[2] ? 2'd2 : 2'd3;
  assign sel = 4'b1 << idx;
  assign changed = {en_q, led_q} != {en_p, led_p};
  assign blank = led_q[7:1] == 7'h7F;
  assign ok = known && (HEX || value < 4'd10);
  assign frame = (seen | sel) == 4'hF;
  always_comb begin
    value = '0;
    known = 1'b0;
    for (int k = 0; k < 16; k++) if (SEG[8*k+1 +: 7] == led_q[7:1]) begin value = 4'(k); known = 1'b1; end
  end
  always_comb begin
    cnt_next = !legal ? '0 : changed ? CW'(1) : cnt == CW'(SETTLE_CYCLES) ? cnt : cnt + 1'b1;
    hold = state == CAPTURED && !changed;
    cap = legal && !hold && cnt_next == CW'(SETTLE_CYCLES);
    state_next = !legal ? IDLE : (hold || cap) ? CAPTURED : SETTLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      en_q <= 4'hF;
      en_p <= 4'hF;
      led_q <= 8'hFF;
      led_p <= 8'hFF;
      cnt <= '0;
      tcnt <= '0;
      state <= IDLE;
      seen <= '0;
      digits <= '0;
      digit_valid <= '0;
      digit_blank <= '0;
      digit_dp <= '0;
      frame_valid <= 1'b0;
      decode_err <= 1'b0;
      timeout <= 1'b0;
    end else begin
      en_q <= enable;
      led_q <= led_out;
      en_p <= en_q;
      led_p <= led_q;
      cnt <= cnt_next;
      state <= state_next;
      frame_valid <= 1'b0;
      decode_err <= 1'b0;
      if (cap) begin
        tcnt <= '0;
        timeout <= 1'b0;
        digit_dp[idx] <= ~led_q[0];
        digit_valid[idx] <= ok || blank;
        digit_blank[idx] <= blank;
        if (ok || blank) digits[{idx, 2'b00} +: 4] <= ok ? value : 4'd0;
        decode_err <= !ok && !blank;
        frame_valid <= frame;
        seen <= frame ? 4'h0 : seen | sel;
      end else begin
        tcnt <= tcnt == TW'(TIMEOUT_CYCLES) ? tcnt : tcnt + 1'b1;
        if (tcnt >= TW'(TIMEOUT_CYCLES - 1)) begin
          timeout <= 1'b1;
          digit_valid <= '0;
          seen <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_seven_segment_capture.sv
// tb_seven_segment_capture: randomized and directed check of two capture instances (HEX=0/1) against a run-length reference model
module tb_seven_segment_capture;
  localparam int S = 4;
  localparam int T = 1024;
  logic clk, reset;
  logic [3:0] enable;
  logic [7:0] led_out;
  logic [15:0] dig [2];
  logic [3:0] val [2], blk [2], dpo [2];
  logic fv [2], de [2], to [2];
  int tests, fails;
  byte unsigned seg [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                             8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
  int run;
  logic [3:0] last_en;
  logic [7:0] last_led;
  logic [15:0] m_dig [2];
  logic [3:0] m_val [2], m_blk [2], m_dp [2], m_seen [2];
  logic m_fv [2], m_de [2], m_to [2];
  int m_idle [2];
  seven_segment_capture #(.HEX(1'b0), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .led_out(led_out), .digits(dig[0]),
    .digit_valid(val[0]), .digit_blank(blk[0]), .digit_dp(dpo[0]), .frame_valid(fv[0]),
    .decode_err(de[0]), .timeout(to[0]));
  seven_segment_capture #(.HEX(1'b1), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .led_out(led_out), .digits(dig[1]),
    .digit_valid(val[1]), .digit_blank(blk[1]), .digit_dp(dpo[1]), .frame_valid(fv[1]),
    .decode_err(de[1]), .timeout(to[1]));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic model_step();
    int i, k;
    bit found, ok, bl;
    logic [3:0] sel;
    if (reset) begin
      run = 0;
      last_en = 4'hF;
      last_led = 8'hFF;
      for (int m = 0; m < 2; m++) begin
        m_dig[m] = '0; m_val[m] = '0; m_blk[m] = '0; m_dp[m] = '0; m_seen[m] = '0;
        m_fv[m] = 1'b0; m_de[m] = 1'b0; m_to[m] = 1'b0; m_idle[m] = 0;
      end
      return;
    end
    i = 3;
    for (int b = 3; b >= 0; b--) if (!last_en[b]) i = b;
    sel = 4'b1 << i;
    found = 1'b0;
    k = 0;
    for (int v = 0; v < 16; v++) if (seg[v][7:1] == last_led[7:1]) begin found = 1'b1; k = v; end
    bl = last_led[7:1] == 7'h7F;
    for (int m = 0; m < 2; m++) begin
      m_fv[m] = 1'b0;
      m_de[m] = 1'b0;
      if (run == S) begin
        ok = found && (m == 1 || k < 10);
        m_dp[m][i] = ~last_led[0];
        m_val[m][i] = ok || bl;
        m_blk[m][i] = bl;
        if (ok) m_dig[m][4*i +: 4] = 4'(k);
        else if (bl) m_dig[m][4*i +: 4] = 4'd0;
        m_de[m] = !ok && !bl;
        if ((m_seen[m] | sel) == 4'hF) begin m_fv[m] = 1'b1; m_seen[m] = 4'h0; end
        else m_seen[m] = m_seen[m] | sel;
        m_idle[m] = 0;
        m_to[m] = 1'b0;
      end else begin
        m_idle[m] = m_idle[m] < T ? m_idle[m] + 1 : T;
        if (m_idle[m] == T) begin m_to[m] = 1'b1; m_val[m] = '0; m_seen[m] = '0; end
      end
    end
    if ($onehot(~enable)) run = (enable == last_en && led_out == last_led) ? run + 1 : 1;
    else run = 0;
    last_en = enable;
    last_led = led_out;
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      check($sformatf("h%0d_digits", m), 32'(dig[m]), 32'(m_dig[m]));
      check($sformatf("h%0d_valid", m), 32'(val[m]), 32'(m_val[m]));
      check($sformatf("h%0d_blank", m), 32'(blk[m]), 32'(m_blk[m]));
      check($sformatf("h%0d_dp", m), 32'(dpo[m]), 32'(m_dp[m]));
      check($sformatf("h%0d_pulses", m), {30'd0, fv[m], de[m]}, {30'd0, m_fv[m], m_de[m]});
      check($sformatf("h%0d_timeout", m), 32'(to[m]), 32'(m_to[m]));
    end
  endtask
  task automatic hold(logic [3:0] e, logic [7:0] l, int n);
    enable = e;
    led_out = l;
    repeat (n) tick();
  endtask
  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    hold(4'hF, 8'hFF, 2);
    check("reset_digits", 32'(dig[0]), 32'h0);
    check("reset_flags", {25'd0, to[0], fv[0], de[0], val[0]}, 32'h0);
    reset = 1'b0;
    hold(4'hE, 8'h25, 4);
    check("t1_not_yet", 32'(val[0]), 32'h0);
    hold(4'hE, 8'h25, 1);
    check("t1_digit", 32'(dig[0][3:0]), 32'h2);
    check("t1_valid", 32'(val[0]), 32'h1);
    hold(4'hE, 8'h25, 7);
    hold(4'hE, 8'h9F, 16);
    hold(4'hD, 8'h25, 16);
    hold(4'hB, 8'h0D, 16);
    hold(4'h7, 8'h99, 16);
    check("t2_digits", 32'(dig[0]), 32'h4321);
    check("t2_valid", 32'(val[0]), 32'hF);
    for (int j = 0; j < 10; j++) hold(4'hD, j[0] ? 8'h0D : 8'h25, 2);
    hold(4'hD, 8'h25, 2);
    hold(4'hD, 8'h0D, S + 1);
    check("t3_digit", 32'(dig[0][7:4]), 32'h3);
    hold(4'hB, 8'h11, 8);
    check("t4_h0_valid2", 32'(val[0][2]), 32'h0);
    check("t4_h1_digit2", 32'(dig[1][11:8]), 32'hA);
    hold(4'hC, 8'h25, 5);
    hold(4'hF, 8'hFF, 1100);
    check("t5_timeout", 32'(to[0]), 32'h1);
    check("t5_valid", 32'(val[0]), 32'h0);
    hold(4'hE, 8'h9F, 6);
    check("t5_cleared", 32'(to[0]), 32'h0);
    hold(4'h7, 8'h00, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    hold(4'h7, 8'h00, S);
    check("t6_no_early", 32'(val[0]), 32'h0);
    hold(4'h7, 8'h00, 1);
    check("t6_digit", 32'(dig[0][15:12]), 32'h8);
    check("t6_dp", 32'(dpo[0][3]), 32'h1);
    for (int j = 0; j < 300; j++) begin
      logic [3:0] e;
      logic [7:0] l;
      int r, q;
      r = $urandom_range(0, 9);
      e = r < 8 ? ~(4'b1 << r[1:0]) : 4'($urandom);
      q = $urandom_range(0, 9);
      l = q < 7 ? seg[$urandom_range(0, 15)] : q == 7 ? 8'hFF : 8'($urandom);
      if ($urandom_range(0, 1) == 1) l[0] = 1'b0;
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
      hold(e, l, $urandom_range(1, 8));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
